// File: rtl/shift_sequencer_if.sv
// Bus bundle between the shift sequencer, its requester and the external shift register.
// The slave side is the sequencer; the master side is the requester plus the shift register.
interface shift_sequencer_if #(
   parameter int width = 8
);
   logic             start;
   logic             abort;
   logic [width-1:0] tx_data;
   logic             busy;
   logic             done;
   logic [width-1:0] rx_data;
   logic             sr_pload;
   logic [width-1:0] sr_pdata;
   logic             sr_pclk;
   logic [width-1:0] sr_pdataOut;

   modport master (
      output start, abort, tx_data, sr_pdataOut,
      input  busy, done, rx_data, sr_pload, sr_pdata, sr_pclk
   );

   modport slave (
      input  start, abort, tx_data, sr_pdataOut,
      output busy, done, rx_data, sr_pload, sr_pdata, sr_pclk
   );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences one parallel-load plus width sr_pclk periods on an external shift register,
// then captures its parallel contents into rx_data.
module shift_sequencer #(
   parameter int width  = 8,
   parameter int clkdiv = 2
) (
   input logic              clk,
   input logic              reset,
   shift_sequencer_if.slave bus
);
   localparam int         BW       = $clog2(width + 1);
   localparam logic [7:0] DIV_LAST = 8'(clkdiv - 1);

   typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_e;

   state_e           state_q, state_d;
   logic [7:0]       div_q, div_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [width-1:0] pdata_q, pdata_d;
   logic [width-1:0] rx_q, rx_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         pdata_q <= '0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         pdata_q <= pdata_d;
         rx_q    <= rx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      pdata_d = pdata_q;
      rx_d    = rx_q;
      case (state_q)
         IDLE: begin
            // abort beats a simultaneous start
            if (bus.start && !bus.abort) begin
               pdata_d = bus.tx_data;
               state_d = LOAD;
            end
         end
         LOAD: begin
            bit_d   = '0;
            div_d   = '0;
            state_d = LOW;
         end
         LOW: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               bit_d   = bit_q + BW'(1);
               state_d = HIGH;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         HIGH: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = (bit_q == BW'(width)) ? DONE : LOW;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         DONE: begin
            rx_d    = bus.sr_pdataOut;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.abort && state_q != IDLE) begin
         state_d = IDLE;
         div_d   = '0;
         rx_d    = rx_q;
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.sr_pload = (state_q == LOAD);
   assign bus.sr_pclk  = (state_q == HIGH);
   assign bus.sr_pdata = pdata_q;
   assign bus.rx_data  = rx_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: two sequencers (clkdiv 2 and 3) each driving a modelled shift register.
module tb_shift_sequencer;
  logic clk, reset;
  logic start, abort, sel;
  logic [7:0] tx_data;
  logic [1:0] mode;
  logic [7:0] qa, qb;
  logic pa, pb;
  int checks = 0;
  int errors = 0;

  shift_sequencer_if #(.width(8)) ifa();
  shift_sequencer_if #(.width(8)) ifb();

  shift_sequencer #(.width(8), .clkdiv(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  shift_sequencer #(.width(8), .clkdiv(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  assign ifa.start = start & !sel;
  assign ifb.start = start & sel;
  assign ifa.abort = abort & !sel;
  assign ifb.abort = abort & sel;
  assign ifa.tx_data = tx_data;
  assign ifb.tx_data = tx_data;
  assign ifa.sr_pdataOut = qa;
  assign ifb.sr_pdataOut = qb;

  // shift register model: parallel load, shift MSB-first on a detected rising sr_pclk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qa <= '0; qb <= '0; pa <= 1'b0; pb <= 1'b0;
    end else begin
      pa <= ifa.sr_pclk;
      pb <= ifb.sr_pclk;
      if (ifa.sr_pload) qa <= ifa.sr_pdata;
      else if (ifa.sr_pclk && !pa) qa <= {qa[6:0], (mode == 2'd2) ? qa[7] : mode[0]};
      if (ifb.sr_pload) qb <= ifb.sr_pdata;
      else if (ifb.sr_pclk && !pb) qb <= {qb[6:0], (mode == 2'd2) ? qb[7] : mode[0]};
    end
  end

  logic s_busy, s_done, s_pload, s_pclk;
  logic [7:0] s_pdata, s_rx;
  assign s_busy  = sel ? ifb.busy     : ifa.busy;
  assign s_done  = sel ? ifb.done     : ifa.done;
  assign s_pload = sel ? ifb.sr_pload : ifa.sr_pload;
  assign s_pclk  = sel ? ifb.sr_pclk  : ifa.sr_pclk;
  assign s_pdata = sel ? ifb.sr_pdata : ifa.sr_pdata;
  assign s_rx    = sel ? ifb.rx_data  : ifa.rx_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one transfer; k counts cycles after the start-accept cycle, sampled on negedges
  task automatic run_xfer(input logic [7:0] data, input int limit, input int rs1, input int rs2,
                          input int ab, output int lat, output int ndone, output int rises,
                          output int loads, output int bad, output int idle_k);
    logic pp;
    pp = 1'b0; lat = -1; ndone = 0; rises = 0; loads = 0; bad = 0; idle_k = -1;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; tx_data = data;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (s_done) begin ndone++; if (lat < 0) lat = k; end
      if (s_pclk && !pp) rises++;
      pp = s_pclk;
      if (s_pload) loads++;
      if (s_pload && s_pclk) bad++;
      if (s_pdata !== data) bad++;
      if (ab > 0 && k > ab && idle_k < 0 && !s_busy) begin
        idle_k = k;
        if (s_pclk || s_pload) bad++;
      end
      start = (k == rs1 || k == rs2);
      abort = (k == ab);
      tx_data = start ? ~data : data;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; tx_data = 8'h00; mode = 2'd2;
    #3;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", ifa.done); end
    checks++; if (ifa.sr_pload !== 1'b0) begin errors++; $display("FAIL rst_pload: got %b want 0", ifa.sr_pload); end
    checks++; if (ifa.sr_pclk !== 1'b0) begin errors++; $display("FAIL rst_pclk: got %b want 0", ifa.sr_pclk); end
    checks++; if (ifa.sr_pdata !== 8'h00) begin errors++; $display("FAIL rst_pdata: got %h want 00", ifa.sr_pdata); end
    checks++; if (ifa.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx: got %h want 00", ifa.rx_data); end
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_b: got %b want 0", ifb.busy); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_loopback();
    int lat, nd, ri, ld, bad, ik;
    mode = 2'd2; sel = 1'b0;
    run_xfer(8'hA5, 40, -1, -1, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (lat !== 34) begin errors++; $display("FAIL loop_lat: got %0d want 34", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL loop_ndone: got %0d want 1", nd); end
    checks++; if (ri !== 8) begin errors++; $display("FAIL loop_rises: got %0d want 8", ri); end
    checks++; if (ld !== 1) begin errors++; $display("FAIL loop_loads: got %0d want 1", ld); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL loop_bad: got %0d want 0", bad); end
    checks++; if (ifa.rx_data !== 8'hA5) begin errors++; $display("FAIL loop_rx: got %h want a5", ifa.rx_data); end
  endtask

  task automatic test_tied();
    int lat, nd, ri, ld, bad, ik;
    mode = 2'd1; sel = 1'b0;
    run_xfer(8'h00, 40, -1, -1, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (ifa.rx_data !== 8'hFF) begin errors++; $display("FAIL tied1_rx: got %h want ff", ifa.rx_data); end
    mode = 2'd0;
    run_xfer(8'hFF, 40, -1, -1, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (ifa.rx_data !== 8'h00) begin errors++; $display("FAIL tied0_rx: got %h want 00", ifa.rx_data); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL tied0_lat: got %0d want 34", lat); end
  endtask

  task automatic test_start_ignored();
    int lat, nd, ri, ld, bad, ik;
    mode = 2'd2; sel = 1'b0;
    run_xfer(8'h96, 40, 5, 20, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (nd !== 1) begin errors++; $display("FAIL ign_ndone: got %0d want 1", nd); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL ign_lat: got %0d want 34", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ign_pdata: got %0d want 0", bad); end
    checks++; if (ifa.rx_data !== 8'h96) begin errors++; $display("FAIL ign_rx: got %h want 96", ifa.rx_data); end
  endtask

  task automatic test_abort();
    int lat, nd, ri, ld, bad, ik;
    mode = 2'd2; sel = 1'b0;
    run_xfer(8'h5A, 40, -1, -1, 10, lat, nd, ri, ld, bad, ik);
    checks++; if (ik !== 11) begin errors++; $display("FAIL abort_idle: got %0d want 11", ik); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_ndone: got %0d want 0", nd); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_bad: got %0d want 0", bad); end
    checks++; if (ifa.rx_data !== 8'h96) begin errors++; $display("FAIL abort_rx: got %h want 96", ifa.rx_data); end
    run_xfer(8'h3C, 40, -1, -1, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (ifa.rx_data !== 8'h3C) begin errors++; $display("FAIL abort_next_rx: got %h want 3c", ifa.rx_data); end
  endtask

  task automatic test_abort_idle();
    int nd;
    nd = 0; sel = 1'b0;
    @(negedge clk); start = 1'b1; abort = 1'b1; tx_data = 8'h11;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL abidle_busy: got %b want 0", ifa.busy); end
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (ifa.done) nd++; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abidle_done: got %0d want 0", nd); end
    checks++; if (ifa.sr_pdata !== 8'h3C) begin errors++; $display("FAIL abidle_pdata: got %h want 3c", ifa.sr_pdata); end
  endtask

  task automatic test_reset_mid();
    int lat, nd, ri, ld, bad, ik;
    int found;
    mode = 2'd2; sel = 1'b0; found = 0; nd = 0;
    @(negedge clk); start = 1'b1; tx_data = 8'h3C;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && found == 0; i++) begin @(negedge clk); if (ifa.sr_pclk) found = 1; end
    checks++; if (found !== 1) begin errors++; $display("FAIL rmid_high: got %0d want 1", found); end
    @(posedge clk); #2 reset = 1'b1; #1;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", ifa.busy); end
    checks++; if (ifa.sr_pclk !== 1'b0) begin errors++; $display("FAIL rmid_pclk: got %b want 0", ifa.sr_pclk); end
    checks++; if (ifa.sr_pdata !== 8'h00) begin errors++; $display("FAIL rmid_pdata: got %h want 00", ifa.sr_pdata); end
    checks++; if (ifa.rx_data !== 8'h00) begin errors++; $display("FAIL rmid_rx: got %h want 00", ifa.rx_data); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (ifa.done) nd++; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rmid_done: got %0d want 0", nd); end
    sel = 1'b1;
    run_xfer(8'hC3, 56, -1, -1, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (lat !== 50) begin errors++; $display("FAIL div3_lat: got %0d want 50", lat); end
    checks++; if (ri !== 8) begin errors++; $display("FAIL div3_rises: got %0d want 8", ri); end
    checks++; if (ifb.rx_data !== 8'hC3) begin errors++; $display("FAIL div3_rx: got %h want c3", ifb.rx_data); end
    sel = 1'b0;
    run_xfer(8'h81, 40, -1, -1, -1, lat, nd, ri, ld, bad, ik);
    checks++; if (lat !== 34) begin errors++; $display("FAIL rmid_next_lat: got %0d want 34", lat); end
    checks++; if (ifa.rx_data !== 8'h81) begin errors++; $display("FAIL rmid_next_rx: got %h want 81", ifa.rx_data); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tied();
    test_start_ignored();
    test_abort();
    test_abort_idle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
